// File: rtl/gppm_pkg.sv
// Shared definitions for the GPPM LED monitor: channel count, level width, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gppm_pkg;

   localparam int LED_CH  = 8;
   localparam int LEVEL_W = 8;

   typedef enum logic {
      GPPM_MON_IDLE    = 1'b0,
      GPPM_MON_MEASURE = 1'b1
   } gppm_mon_state_e;

endpackage

// File: rtl/gppm_duty_channel.sv
// One LED channel: high-time accumulator, scaling to an 8-bit level with saturation, change flag.
// Latency: level/changed update on the edge where latch is high (that edge's sample included).
// Backpressure: none; the accumulator is advanced every cycle by the shared window control.
//
// Ports:
//   clk, reset      - clock, async active-high reset
//   clear           - zero the accumulator (idle or aborted window)
//   sample          - synchronized LED bit, already gated by "measuring"
//   latch           - last cycle of the window: publish level, recompute changed
//   level, changed  - registered outputs, held between latches
module gppm_duty_channel
   import gppm_pkg::*;
#(
   parameter int PERIOD_LOG2 = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               sample,
   input  logic               latch,
   output logic [LEVEL_W-1:0] level,
   output logic               changed
);

   // One extra bit so a fully-high window (2**PERIOD_LOG2) is representable.
   logic [PERIOD_LOG2:0] acc_q, acc_d, acc_inc;
   logic [LEVEL_W-1:0]   level_q, level_d, level_new;
   logic                 changed_q, changed_d;

   always_comb begin
      acc_inc = acc_q + {{PERIOD_LOG2{1'b0}}, sample};
      // acc >> (PERIOD_LOG2-8) is acc_inc[PERIOD_LOG2 -: 9]; the top bit can only
      // be set for the full count 256, which saturates to 255.
      level_new = acc_inc[PERIOD_LOG2] ? {LEVEL_W{1'b1}}
                                       : acc_inc[PERIOD_LOG2-1 -: LEVEL_W];
      acc_d     = acc_inc;
      level_d   = level_q;
      changed_d = changed_q;
      if (latch) begin
         // Window end wins over clear so a latch on an enable-drop edge completes.
         acc_d     = '0;
         level_d   = level_new;
         changed_d = (level_new != level_q);
      end else if (clear) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q     <= '0;
         level_q   <= '0;
         changed_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         level_q   <= level_d;
         changed_q <= changed_d;
      end
   end

   assign level   = level_q;
   assign changed = changed_q;

endmodule

// File: rtl/gppm_led_monitor.sv
// Brightness monitor: synchronizes the eight LED lines and reports per-channel duty once per window.
// Latency: 2-cycle input sync; frame_done exactly 2**PERIOD_LOG2 cycles after enable is sampled high.
// Backpressure: none; results are overwritten every window, enable low idles/aborts.
//
// Ports:
//   clk, reset  - clock, async active-high reset
//   enable      - run measurement; dropping it mid-window discards the partial window
//   leds        - asynchronous LED lines under observation
//   duty        - channel i level at duty[8*i+7:8*i]
//   changed     - bit i set when channel i's latest level differs from the previous one
//   frame_done  - one-cycle pulse on the edge duty/changed update
// PERIOD_LOG2 must be >= 8.
module gppm_led_monitor
   import gppm_pkg::*;
#(
   parameter int PERIOD_LOG2 = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [LED_CH-1:0]         leds,
   output logic [LED_CH*LEVEL_W-1:0] duty,
   output logic [LED_CH-1:0]         changed,
   output logic                      frame_done
);

   gppm_mon_state_e        state_q, state_d;
   logic [LED_CH-1:0]      sync1_q, sync1_d;
   logic [LED_CH-1:0]      led_s_q, led_s_d;
   logic [PERIOD_LOG2-1:0] wcnt_q, wcnt_d;
   logic                   frame_done_q, frame_done_d;
   logic                   measuring, win_end, acc_clear;
   logic [LED_CH-1:0]      acc_sample;

   always_comb begin
      sync1_d      = leds;
      led_s_d      = sync1_q;
      measuring    = (state_q == GPPM_MON_MEASURE);
      win_end      = measuring && (wcnt_q == {PERIOD_LOG2{1'b1}});
      acc_clear    = !measuring || !enable;
      acc_sample   = measuring ? led_s_q : '0;
      frame_done_d = win_end;
      state_d      = state_q;
      wcnt_d       = '0;
      case (state_q)
         GPPM_MON_IDLE: begin
            if (enable) state_d = GPPM_MON_MEASURE;
         end
         GPPM_MON_MEASURE: begin
            // The counter wraps from max to 0, so windows run back to back.
            if (enable) wcnt_d = wcnt_q + {{(PERIOD_LOG2-1){1'b0}}, 1'b1};
            else        state_d = GPPM_MON_IDLE;
         end
         default: state_d = GPPM_MON_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= GPPM_MON_IDLE;
         sync1_q      <= '0;
         led_s_q      <= '0;
         wcnt_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         led_s_q      <= led_s_d;
         wcnt_q       <= wcnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   for (genvar i = 0; i < LED_CH; i++) begin : g_ch
      gppm_duty_channel #(
         .PERIOD_LOG2 (PERIOD_LOG2)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .clear   (acc_clear),
         .sample  (acc_sample[i]),
         .latch   (win_end),
         .level   (duty[i*LEVEL_W +: LEVEL_W]),
         .changed (changed[i])
      );
   end

   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gppm_led_monitor.sv
// Self-checking bench for gppm_led_monitor (PERIOD_LOG2 = 8 and 10 instances).
// Expected levels come from counting high samples over each window in a recorded LED history.
// Stimulus is a directed sequence with randomized LED patterns.
module tb_gppm_led_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [7:0]  leds = 8'hFF;
   logic [63:0] duty8, duty10;
   logic [7:0]  changed8, changed10;
   logic        fd8, fd10;

   int total = 0;
   int bad = 0;
   int ecnt = 0;
   logic [7:0]  hist [32768];
   logic [63:0] prev8 = '0;
   logic [63:0] prev10 = '0;

   gppm_led_monitor #(.PERIOD_LOG2(8)) dut8 (
      .clk(clk), .reset(reset), .enable(enable), .leds(leds),
      .duty(duty8), .changed(changed8), .frame_done(fd8));

   gppm_led_monitor #(.PERIOD_LOG2(10)) dut10 (
      .clk(clk), .reset(reset), .enable(enable), .leds(leds),
      .duty(duty10), .changed(changed10), .frame_done(fd10));

   always #5 clk = ~clk;

   // Edge index and the LED value present at each rising edge.
   always @(posedge clk) begin
      ecnt = ecnt + 1;
      if (ecnt < 32768) hist[ecnt] = leds;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // A sample counted at edge e is the LED value seen at edge e-2 (synchronizer).
   // Window ending at edge f covers edges f-W+1 .. f.
   function automatic logic [63:0] exp_frame(input int f, input int lg);
      int w = 1 << lg;
      logic [63:0] r = '0;
      for (int ch = 0; ch < 8; ch++) begin
         int sum = 0;
         for (int e = f - w + 1; e <= f; e++) sum += int'(hist[e-2][ch]);
         sum = sum >> (lg - 8);
         if (sum > 255) sum = 255;
         r[8*ch +: 8] = 8'(sum);
      end
      return r;
   endfunction

   function automatic logic [7:0] gen(input int mode, input int cyc);
      logic [7:0] v = '0;
      case (mode)
         1: v[0] = ((cyc % 16) < 8);
         2: v = 8'($urandom);
         3: for (int i = 0; i < 8; i++) v[i] = ($urandom_range(8) <= i);
         4: v[3] = ((cyc % 32) < 16);
         default: v = leds;
      endcase
      return v;
   endfunction

   task automatic tick(input int mode);
      @(negedge clk);
      leds = gen(mode, ecnt);
   endtask

   task automatic go_enable(output int s);
      @(negedge clk);
      enable = 1'b1;
      s = ecnt + 1;
   endtask

   task automatic wait_frame(input bit big, input int exp_edge, input int mode, input string tag);
      int n = 0;
      bit seen = 0;
      int got = -1;
      logic [63:0] e;
      logic [7:0]  ec;
      while (!seen && n < 3000) begin
         @(negedge clk);
         n++;
         if ((big ? fd10 : fd8) === 1'b1) begin
            seen = 1;
            got = ecnt;
         end
         leds = gen(mode, ecnt);
      end
      chk({tag, "_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         chk({tag, "_edge"}, 64'(got), 64'(exp_edge));
         e = exp_frame(got, big ? 10 : 8);
         for (int ch = 0; ch < 8; ch++)
            ec[ch] = (e[8*ch +: 8] != (big ? prev10[8*ch +: 8] : prev8[8*ch +: 8]));
         chk({tag, "_duty"}, big ? duty10 : duty8, e);
         chk({tag, "_chg"}, 64'(big ? changed10 : changed8), 64'(ec));
         if (big) prev10 = e; else prev8 = e;
         tick(mode);
         chk({tag, "_pulse"}, 64'(big ? fd10 : fd8), 64'd0);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_duty8"}, duty8, 64'd0);
      chk({tag, "_chg8"}, 64'(changed8), 64'd0);
      chk({tag, "_fd8"}, 64'(fd8), 64'd0);
      chk({tag, "_duty10"}, duty10, 64'd0);
      chk({tag, "_chg10"}, 64'(changed10), 64'd0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      enable = 1'b0;
      #1;
      chk_zero(tag);
      prev8 = '0;
      prev10 = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int s;
      int cnt;

      // Reset values, no frame while disabled.
      #100;
      chk_zero("rst");
      @(negedge clk);
      reset = 1'b0;
      cnt = 0;
      repeat (20) begin
         tick(0);
         if (fd8 || fd10) cnt++;
      end
      chk("idle_nofd", 64'(cnt), 64'd0);

      // Full duty for three windows, then zero.
      go_enable(s);
      for (int k = 1; k <= 3; k++) wait_frame(0, s + 256*k, 0, "full");
      chk("full_duty", duty8, {8{8'hFF}});
      chk("full_chg_late", 64'(changed8), 64'd0);
      leds = 8'h00;
      wait_frame(0, s + 1024, 0, "zero_a");
      wait_frame(0, s + 1280, 0, "zero_b");
      chk("zero_duty", duty8, 64'd0);

      // 50% square wave on channel 0, then randomized patterns.
      wait_frame(0, s + 1536, 1, "sq_a");
      wait_frame(0, s + 1792, 1, "sq_b");
      chk("sq_ch0", 64'(duty8[7:0]), 64'h80);
      chk("sq_others", 64'(duty8[63:8]), 64'd0);
      wait_frame(0, s + 2048, 3, "bias_a");
      wait_frame(0, s + 2304, 3, "bias_b");
      wait_frame(0, s + 2560, 2, "rand_a");

      // Scaling and saturation on the 1024-cycle instance.
      do_reset("rst_p10");
      repeat (5) tick(4);
      go_enable(s);
      wait_frame(1, s + 1024, 4, "p10_sq");
      chk("p10_ch3", 64'(duty10[31:24]), 64'h80);
      leds = 8'hFF;
      wait_frame(1, s + 2048, 0, "p10_mix");
      wait_frame(1, s + 3072, 0, "p10_full");
      chk("p10_sat", duty10, {8{8'hFF}});

      // Abort mid-window, re-enable, glitch, and enable low on the window-end cycle.
      do_reset("rst_ab");
      repeat (5) tick(2);
      go_enable(s);
      wait_frame(0, s + 256, 2, "ab_pre");
      while (ecnt < s + 356) tick(2);
      enable = 1'b0;
      cnt = 0;
      repeat (300) begin
         tick(2);
         if (fd8) cnt++;
      end
      chk("ab_nofd", 64'(cnt), 64'd0);
      chk("ab_hold", duty8, prev8);
      go_enable(s);
      wait_frame(0, s + 256, 2, "ab_re");
      while (ecnt < s + 306) tick(2);
      @(negedge clk);
      enable = 1'b0;
      go_enable(s);
      wait_frame(0, s + 256, 2, "glitch");
      while (ecnt < s + 511) tick(2);
      enable = 1'b0;
      wait_frame(0, s + 512, 2, "endlow");
      cnt = 0;
      repeat (300) begin
         tick(2);
         if (fd8) cnt++;
      end
      chk("endlow_idle", 64'(cnt), 64'd0);

      // Reset in the middle of a window.
      go_enable(s);
      while (ecnt < s + 200) tick(2);
      do_reset("rst_mid");
      repeat (4) tick(2);
      go_enable(s);
      wait_frame(0, s + 256, 2, "rst_re");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gppm_led_monitor.md
# gppm_led_monitor

Brightness monitor for the GPPM LED outputs: samples the eight `leds` lines, measures each channel's high-time over a fixed window, and reports an 8-bit duty level per channel once per window. It is the reading end of the `gppm_top` LED interface. `gppm_top` turns switch settings into PWM patterns on `leds`; this block recovers the brightness levels from those patterns. It is used for on-board self-check and as the scoreboard source in system benches.

## Interface
- `PERIOD_LOG2`, default 8: window length is 2**PERIOD_LOG2 clocks; must be ≥ 8.
- `clk`, input, 1: system clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: high runs measurement; low idles the block.
- `leds`, input, 8: LED lines under observation. Asynchronous to the measurement window.
- `duty`, output, 64: per-channel level; channel i is at `duty[8*i+7:8*i]`.
- `changed`, output, 8: bit i is high if channel i's level differs from its previous latched value.
- `frame_done`, output, 1: one-cycle pulse when `duty` and `changed` update.

## Operation
- **Input synchronizer:** `leds` passes through a 2-flop synchronizer to give `led_s`. All counting uses `led_s`.
- **State IDLE:**
  - Window counter and accumulators are held at 0.
  - Outputs hold their last latched values.
  - `enable` sampled high moves to MEASURE on the next edge.
- **State MEASURE:**
  - Window counter `wcnt` runs 0 .. 2**PERIOD_LOG2 - 1.
  - Each cycle, `acc[i]` increments when `led_s[i]` is 1.
  - `acc` width is PERIOD_LOG2+1 bits, so it can hold the full count 2**PERIOD_LOG2.
- **Window end (`wcnt` at its maximum, current sample included):**
  - Compute `level = acc >> (PERIOD_LOG2-8)`.
  - If the result is 256, saturate it to 255.
  - Latch `level` into `duty`.
  - Set `changed[i] = (new level != old duty[i])`.
  - Pulse `frame_done`.
  - Clear `acc` and `wcnt`. The next window starts immediately, with no gap.
- **`enable` falls mid-window:**
  - The partial window is discarded and the block returns to IDLE.
  - No `frame_done` is produced; `duty` and `changed` are retained.
- **`enable` falls on the window-end cycle:** the latch completes first, then the block goes to IDLE.
- **Reset (any time, including mid-window):**
  - State returns to IDLE immediately.
  - `duty`, `changed`, `frame_done`, `acc`, `wcnt` and the synchronizer flops all go to 0.
- **Change detection in the first window after reset:** compares against `duty` = 0.

## Timing
- **Synchronizer latency:** a change on `leds` first counts 2 cycles later.
- **Start of first window:** the first counted cycle is the cycle after the edge where `enable` is sampled high. `frame_done` is asserted exactly 2**PERIOD_LOG2 cycles after that edge.
- **Update timing:** `duty`, `changed` and `frame_done` update on the same edge. `frame_done` is high for exactly 1 cycle.
- **Steady state:** `frame_done` repeats every 2**PERIOD_LOG2 cycles while `enable` stays high.
- **`enable` glitch:** a 1-cycle low pulse on `enable` restarts window alignment.

## Structure
- **Shared package `gppm_pkg`:**
  - `LED_CH` = 8.
  - `LEVEL_W` = 8.
  - State enum: `GPPM_MON_IDLE`, `GPPM_MON_MEASURE`.
- **Sub-module `gppm_duty_channel`:**
  - Contents: one accumulator, the scaling/saturation logic, and the change compare.
  - Inputs: `clk`, `reset`, `clear`, `sample`, `latch`.
  - Outputs: `level`, `changed`.
  - Instantiated `LED_CH` times, driven by a single shared window FSM/counter in the top.

## Test plan
Concrete values below assume `PERIOD_LOG2` = 8.
1. **Reset values:** assert `reset` for 100 ns with `leds` = 0xFF → all outputs 0; `frame_done` stays 0 while `enable` = 0.
2. **Full and zero duty:** `leds` = 0xFF, `enable` = 1 for 3 windows → every `duty` byte = 0xFF; `frame_done` is a 1-cycle pulse every 256 cycles; `changed` = 0xFF after the first window, 0x00 after later ones. Then `leds` = 0x00 → `duty` = 0 in the second window after the change.
3. **50 % duty:** `leds[0]` is a square wave, 8 high / 8 low, others 0 → `duty[7:0]` = 0x80 ± 1 from the second window on; other channels 0.
4. **Scaling and saturation:** `PERIOD_LOG2` = 10, `leds[3]` high for 512 of 1024 cycles per window → `duty[31:24]` = 0x80; constant-high input → 0xFF, not wrapping to 0x00.
5. **Abort:** drop `enable` at cycle 100 of a window → no `frame_done`; `duty` unchanged. Re-enable → first `frame_done` exactly 256 cycles after re-enable.
6. **Reset mid-window:** reset at cycle 200 → outputs clear immediately; no `frame_done` until 256 cycles after re-enable.
